// File: rtl/riscof_tb_ctrl_periph.sv
// Test-control peripheral on the core data bus: stdout FIFO, sticky pass/fail
// flags, deferred exit report, free-running cycle counter and compare timer irq.
module riscof_tb_ctrl_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  input  logic        stdout_ready_i,
  output logic [7:0]  stdout_data_o,
  output logic        irq_timer_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] OFF_STDOUT = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_EXIT   = 3'd2;
  localparam logic [2:0] OFF_CYCLE  = 3'd3;
  localparam logic [2:0] OFF_CMP    = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   timer_cmp_q, timer_cmp_d;
  logic          timer_en_q, timer_en_d;
  logic          irq_q, irq_d;
  logic          passed_q, passed_d, failed_q, failed_d;
  logic [31:0]   exit_value_q, exit_value_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       in_window, wr_en, fifo_empty, fifo_full, pop, push, stdout_wr;
  logic [2:0] offset;
  logic       unused_bits;

  assign unused_bits = ^{data_be_i[3:1], data_addr_i[1:0]};

  assign in_window  = (data_addr_i[31:5] == BASE_ADDR[31:5]);
  assign offset     = data_addr_i[4:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = !fifo_empty && stdout_ready_i;
  assign stdout_wr  = in_window && data_we_i && (offset == OFF_STDOUT);

  // A STDOUT write to a full FIFO is stalled unless a slot frees up this cycle.
  assign data_gnt_o = data_req_i && (state_q == ST_IDLE) &&
                      !(stdout_wr && fifo_full && !pop);
  assign wr_en      = data_gnt_o && in_window && data_we_i;
  assign push       = data_gnt_o && stdout_wr && data_be_i[0];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    timer_cmp_d  = timer_cmp_q;
    timer_en_d   = timer_en_q;
    passed_d     = passed_q;
    failed_d     = failed_q;
    exit_value_d = exit_value_q;
    state_d      = state_q;
    rdata_d      = '0;
    cycle_d      = cycle_q + 32'd1;
    rvalid_d     = data_gnt_o;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_en) begin
      case (offset)
        OFF_STATUS: begin
          if (data_wdata_i == PASS_MAGIC)  passed_d = 1'b1;
          else if (data_wdata_i != '0)     failed_d = 1'b1;
        end
        OFF_EXIT: exit_value_d = data_wdata_i;
        OFF_CMP:  timer_cmp_d  = data_wdata_i;
        OFF_CTRL: timer_en_d   = data_wdata_i[0];
        default: ;
      endcase
    end

    if (data_gnt_o && !data_we_i && in_window) begin
      case (offset)
        OFF_STATUS: rdata_d = {30'b0, failed_q, passed_q};
        OFF_CYCLE:  rdata_d = cycle_q;
        OFF_CMP:    rdata_d = timer_cmp_q;
        OFF_CTRL:   rdata_d = {31'b0, timer_en_q};
        default:    rdata_d = '0;
      endcase
    end

    // Using the next-state compare/enable lets a CMP raise or disable drop the
    // irq on the cycle right after the write.
    irq_d = timer_en_d && (cycle_q >= timer_cmp_d);

    case (state_q)
      ST_IDLE:   if (wr_en && (offset == OFF_EXIT)) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_HALT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cycle_q      <= '0;
      timer_cmp_q  <= '0;
      timer_en_q   <= 1'b0;
      irq_q        <= 1'b0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_value_q <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cycle_q      <= cycle_d;
      timer_cmp_q  <= timer_cmp_d;
      timer_en_q   <= timer_en_d;
      irq_q        <= irq_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_value_q <= exit_value_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone decide what
  // is valid, and the output is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_wdata_i[7:0];
  end

  assign stdout_valid_o = !fifo_empty;
  assign stdout_data_o  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign irq_timer_o    = irq_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = (state_q == ST_REPORT);
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_riscof_tb_ctrl_periph.sv
// Scoreboard bench for riscof_tb_ctrl_periph: bus responses and stdout
// characters are queued when stimulus is granted and compared as they appear.
module tb_riscof_tb_ctrl_periph;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk, rst_ni;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        stdout_valid_o, stdout_ready_i;
  logic [7:0]  stdout_data_o;
  logic        irq_timer_o, tests_passed_o, tests_failed_o, exit_valid_o;
  logic [31:0] exit_value_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] tb_cycle;
  logic [31:0] exp_rdata_q[$];
  logic [7:0]  exp_char_q[$];
  int          pop_log[$];
  int          last_gnt_cycle;
  logic        prev_gnt;

  riscof_tb_ctrl_periph dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .stdout_valid_o (stdout_valid_o),
    .stdout_ready_i (stdout_ready_i),
    .stdout_data_o  (stdout_data_o),
    .irq_timer_o    (irq_timer_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference cycle count: cycles elapsed since reset release.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) tb_cycle <= '0;
    else         tb_cycle <= tb_cycle + 32'd1;
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_gnt = 1'b0;
    end else begin
      if (prev_gnt || data_rvalid_o) check("rvalid_latency", data_rvalid_o, prev_gnt);
      if (data_rvalid_o) begin
        if (exp_rdata_q.size() == 0) check("rvalid_unexpected", data_rvalid_o, 0);
        else                         check("rdata", data_rdata_o, exp_rdata_q.pop_front());
      end
      prev_gnt = data_gnt_o;
      if (stdout_valid_o && stdout_ready_i) begin
        pop_log.push_back(int'(tb_cycle));
        if (exp_char_q.size() == 0) check("stdout_extra", stdout_valid_o, 0);
        else                        check("stdout_data", stdout_data_o, exp_char_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1ns after a rising edge.
  task automatic bus_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] exp_rd);
    bit done = 0;
    data_req_i   = 1'b1;
    data_addr_i  = addr;
    data_we_i    = we;
    data_be_i    = be;
    data_wdata_i = wdata;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (data_gnt_o) begin
        done = 1;
        last_gnt_cycle = int'(tb_cycle);
        if (we)                   exp_rdata_q.push_back(32'h0);
        else if (addr == BASE + 32'h0C) exp_rdata_q.push_back(tb_cycle);
        else                      exp_rdata_q.push_back(exp_rd);
        if (we && addr[31:5] == BASE[31:5] && addr[4:2] == 3'd0 && be[0])
          exp_char_q.push_back(wdata[7:0]);
      end
    end
    if (!done) check("gnt_timeout", data_gnt_o, 1);
    sync();
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_gnt"},          data_gnt_o, 0);
    check({pfx, "_rvalid"},       data_rvalid_o, 0);
    check({pfx, "_rdata"},        data_rdata_o, 0);
    check({pfx, "_stdout_valid"}, stdout_valid_o, 0);
    check({pfx, "_stdout_data"},  stdout_data_o, 0);
    check({pfx, "_irq"},          irq_timer_o, 0);
    check({pfx, "_passed"},       tests_passed_o, 0);
    check({pfx, "_failed"},       tests_failed_o, 0);
    check({pfx, "_exit_valid"},   exit_valid_o, 0);
    check({pfx, "_exit_value"},   exit_value_o, 0);
  endtask

  task automatic apply_reset();
    data_req_i = 1'b0;
    #2 rst_ni = 1'b0;
    exp_rdata_q.delete();
    exp_char_q.delete();
    pop_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    int g, strobes, strobe_cycle, left_at_strobe;
    logic [31:0] val_at_strobe;
    bit seen_gnt, seen_exit;

    rst_ni = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = '0; data_wdata_i = '0; stdout_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_ni = 1'b1;
    sync();
    bus_access(BASE + 32'h0C, 1'b0, 4'hF, '0, '0);

    // Timer compare at 100, then raise CMP / drop enable.
    bus_access(BASE + 32'h10, 1'b1, 4'hF, 32'd100, '0);
    bus_access(BASE + 32'h14, 1'b1, 4'hF, 32'd1, '0);
    for (int i = 0; i < 300 && tb_cycle != 32'd100; i++) @(negedge clk);
    check("irq_at_100", irq_timer_o, 0);
    @(negedge clk);
    check("irq_after_100", irq_timer_o, 1);
    sync();
    bus_access(BASE + 32'h10, 1'b1, 4'hF, 32'hFFFF_FFFF, '0);
    check("irq_cmp_max", irq_timer_o, 0);
    bus_access(BASE + 32'h10, 1'b1, 4'hF, 32'd50, '0);
    check("irq_cmp_50", irq_timer_o, 1);
    bus_access(BASE + 32'h14, 1'b1, 4'hF, 32'd0, '0);
    check("irq_disabled", irq_timer_o, 0);
    bus_access(BASE + 32'h14, 1'b0, 4'hF, '0, 32'd0);
    bus_access(BASE + 32'h14, 1'b1, 4'hF, 32'hFFFF_FFFE, '0);
    bus_access(BASE + 32'h14, 1'b0, 4'hF, '0, 32'd0);
    bus_access(BASE + 32'h10, 1'b0, 4'hF, '0, 32'd50);

    // "Hi" with the consumer always ready.
    stdout_ready_i = 1'b1;
    pop_log.delete();
    bus_access(BASE, 1'b1, 4'h1, 32'h48, '0);
    g = last_gnt_cycle;
    bus_access(BASE, 1'b1, 4'h1, 32'h69, '0);
    repeat (3) @(negedge clk);
    check("hi_pop_count", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      check("hi_first_pop_cycle", pop_log[0], g + 1);
      check("hi_second_pop_cycle", pop_log[1], g + 2);
    end
    sync();
    bus_access(BASE, 1'b1, 4'hE, 32'h5A, '0);
    @(negedge clk);
    check("be0_clear_no_push", stdout_valid_o, 0);

    // Fill the FIFO with ready low; the ninth write must wait for a pop.
    sync();
    stdout_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) bus_access(BASE, 1'b1, 4'h1, 32'h30 + i, '0);
    data_req_i = 1'b1; data_addr_i = BASE; data_we_i = 1'b1;
    data_be_i = 4'h1; data_wdata_i = 32'h39;
    @(negedge clk);
    check("gnt_full_a", data_gnt_o, 0);
    sync();
    @(negedge clk);
    check("gnt_full_b", data_gnt_o, 0);
    sync();
    stdout_ready_i = 1'b1;
    pop_log.delete();
    @(negedge clk);
    check("gnt_full_pop", data_gnt_o, 1);
    if (data_gnt_o) begin
      exp_rdata_q.push_back(32'h0);
      exp_char_q.push_back(8'h39);
    end
    sync();
    data_req_i = 1'b0; data_we_i = 1'b0; stdout_ready_i = 1'b0;
    @(negedge clk);
    check("full_head_after_pop", stdout_data_o, 32'h32);
    sync();
    stdout_ready_i = 1'b1;
    repeat (12) @(negedge clk);
    check("full_pop_total", pop_log.size(), 9);
    check("full_drained", stdout_valid_o, 0);
    sync();

    // Sticky status flags.
    check("passed_before", tests_passed_o, 0);
    bus_access(BASE + 32'h04, 1'b1, 4'hF, MAGIC, '0);
    check("passed_set", tests_passed_o, 1);
    check("failed_clear", tests_failed_o, 0);
    bus_access(BASE + 32'h04, 1'b0, 4'hF, '0, 32'd1);
    bus_access(BASE + 32'h04, 1'b1, 4'hF, 32'd5, '0);
    check("failed_set", tests_failed_o, 1);
    bus_access(BASE + 32'h04, 1'b1, 4'hF, 32'd0, '0);
    bus_access(BASE + 32'h04, 1'b0, 4'hF, '0, 32'd3);

    // Out-of-window and unmapped accesses.
    bus_access(BASE + 32'h30, 1'b1, 4'hF, 32'h1234, '0);
    bus_access(BASE + 32'h10, 1'b0, 4'hF, '0, 32'd50);
    bus_access(BASE + 32'h24, 1'b0, 4'hF, '0, 32'd0);
    bus_access(BASE + 32'h18, 1'b0, 4'hF, '0, 32'd0);
    bus_access(BASE, 1'b0, 4'hF, '0, 32'd0);
    bus_access(BASE + 32'h0C, 1'b0, 4'hF, '0, '0);

    // Exit with three characters queued.
    stdout_ready_i = 1'b0;
    pop_log.delete();
    bus_access(BASE, 1'b1, 4'h1, 32'h78, '0);
    bus_access(BASE, 1'b1, 4'h1, 32'h79, '0);
    bus_access(BASE, 1'b1, 4'h1, 32'h7A, '0);
    bus_access(BASE + 32'h08, 1'b1, 4'hF, 32'h2A, '0);
    data_req_i = 1'b1; data_addr_i = BASE + 32'h04; data_we_i = 1'b0;
    seen_gnt = 0; seen_exit = 0;
    repeat (5) begin
      @(negedge clk);
      seen_gnt |= data_gnt_o;
      seen_exit |= exit_valid_o;
    end
    check("drain_gnt_stalled", seen_gnt, 0);
    check("drain_no_early_exit", seen_exit, 0);
    sync();
    data_req_i = 1'b0;
    stdout_ready_i = 1'b1;
    strobes = 0; left_at_strobe = -1; val_at_strobe = '0;
    repeat (20) begin
      @(negedge clk);
      if (exit_valid_o) begin
        strobes++;
        left_at_strobe = exp_char_q.size();
        val_at_strobe = exit_value_o;
      end
    end
    check("exit_strobe_count", strobes, 1);
    check("exit_after_drain", left_at_strobe, 0);
    check("exit_value_at_strobe", val_at_strobe, 32'h2A);
    check("exit_drained_chars", pop_log.size(), 3);
    check("exit_value_held", exit_value_o, 32'h2A);
    sync();
    data_req_i = 1'b1; data_addr_i = BASE + 32'h04; data_we_i = 1'b0;
    @(negedge clk);
    check("halt_gnt", data_gnt_o, 0);
    sync();

    // Exit with an empty FIFO: strobe two cycles after the grant.
    apply_reset();
    sync();
    bus_access(BASE + 32'h08, 1'b1, 4'hF, 32'h77, '0);
    g = last_gnt_cycle;
    strobe_cycle = -1;
    for (int i = 0; i < 10; i++) begin
      if (exit_valid_o && strobe_cycle < 0) strobe_cycle = int'(tb_cycle);
      @(negedge clk);
    end
    check("exit_empty_latency", strobe_cycle, g + 2);
    check("exit_empty_value", exit_value_o, 32'h77);

    // Asynchronous reset while draining.
    sync();
    apply_reset();
    sync();
    stdout_ready_i = 1'b0;
    bus_access(BASE + 32'h04, 1'b1, 4'hF, 32'd9, '0);
    bus_access(BASE, 1'b1, 4'h1, 32'h61, '0);
    bus_access(BASE, 1'b1, 4'h1, 32'h62, '0);
    bus_access(BASE + 32'h08, 1'b1, 4'hF, 32'h55, '0);
    @(negedge clk);
    check("pre_reset_exit_valid", exit_valid_o, 0);
    check("pre_reset_stdout_valid", stdout_valid_o, 1);
    #2 rst_ni = 1'b0;
    exp_rdata_q.delete();
    exp_char_q.delete();
    pop_log.delete();
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    stdout_ready_i = 1'b1;
    sync();
    bus_access(BASE + 32'h04, 1'b0, 4'hF, '0, 32'd0);
    repeat (3) @(negedge clk);
    check("post_reset_fifo_empty", pop_log.size(), 0);
    sync();
    bus_access(BASE, 1'b1, 4'h1, 32'h51, '0);
    repeat (3) @(negedge clk);
    check("post_reset_char_out", pop_log.size(), 1);
    check("post_reset_exit_value", exit_value_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
